fp_mul_round_pack: RTL and testbench
====================================

# fp_mul_round_pack

Post-multiply normalize/round/pack stage for the single-precision IEEE-754 multiplier. It takes the raw 48-bit significand product, the sign and the unnormalized exponent sum from the shift-add multiplier core. It produces a packed 32-bit result with overflow/underflow flags. It is a 2-stage valid/ready pipeline with round-to-nearest-even, flush-to-zero on underflow, and special-operand override.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock, all state rising-edge
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream has a product
- in_ready  out  1  stage can accept this cycle
- in_sign  in  1  sign_A ^ sign_B
- in_exp  in  10  two's-complement exponent sum expA + expB − 127 (range −127..383)
- in_prod  in  48  {1,fracA} × {1,fracB}, unsigned
- in_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN (pre-classified upstream)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  packed IEEE-754 single
- out_overflow  out  1  result saturated to ±inf
- out_underflow  out  1  result flushed to ±0

## Operation
- Stage 1 (normalize + round, registered into s1):
  - If prod[47]=1: mant = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp = in_exp + 1.
  - Else: mant = prod[45:23], guard = prod[22], sticky = |prod[21:0], exp = in_exp.
  - RNE: round_up = guard & (sticky | mant[0]). mant + round_up is formed at 24 bits.
  - On carry out, mant = 0 and exp = exp + 1.
  - All exponent arithmetic is 10-bit two's complement, with no wrap in the legal range.
- Stage 2 (pack, registered into output), for the normal class:
  - exp ≥ 255 (signed): result {sign, 8'hFF, 23'h0}, overflow = 1.
  - exp ≤ 0 (signed): result {sign, 31'h0}, underflow = 1. No denormals are produced.
  - Otherwise: result {sign, exp[7:0], mant}, both flags 0.
- Special override (flags forced 0, product ignored):
  - zero → {sign, 31'h0}
  - inf → {sign, 8'hFF, 23'h0}
  - NaN → 32'h7FC00000
- Special resolution (0×inf → NaN, NaN propagation) is decided upstream. This stage only applies the code.

## Timing
- Latency is 2 cycles from accepted input to out_valid, given no backpressure. Throughput is 1 result per cycle.
- A transfer occurs on valid & ready at a clk edge. out_valid, out_result and the flags are held stable while out_valid & !out_ready.
- s1 advances into the output register when !out_valid | out_ready.
- in_ready = !s1_valid | (!out_valid | out_ready). This is a combinational path from out_ready to in_ready, which is permitted.
- With both stages full and out_ready=0, in_ready=0. Accepted items leave in order, with no loss or duplication.
- Simultaneous out_ready=1 and in_valid=1 while full: one item leaves, one advances and one enters in the same cycle.
- Reset (async, any time including mid-flight): s1_valid = 0, out_valid = 0, out_result = 32'h0, out_overflow = 0, out_underflow = 0. In-flight data is discarded. in_ready = 1 during and after reset.
- Datapath registers capture only when their stage loads. Their contents are don't-care while the stage's valid is 0.

## Structure
- Shared package fp_pkg:
  - FP_BIAS = 127
  - FP_QNAN = 32'h7FC00000
  - special codes FP_NORM / FP_ZERO / FP_INF / FP_NAN
  - FP_EXP_W = 10
- One sub-module, fp_round_rne: combinational normalize + RNE.
  - Inputs: prod[47:0], exp[9:0].
  - Outputs: mant[22:0], exp[9:0].
  - It is instantiated in stage 1 and reusable by the adder path.
- Top: pipeline valid/ready control, s1 and output registers, pack/override logic.

## Test plan
- 1.5×1.5: in_prod = 48'h900000000000, in_exp = 127, sign 0, special 00, out_ready = 1 → out_result = 32'h40100000 two cycles later, both flags 0.
- Rounding: prod 48'h400000C00000, exp 127 → 32'h3F800002. Tie-even: prod 48'h400000400000 → 32'h3F800000. Mantissa carry: prod 48'h7FFFFFC00000 → 32'h40000000.
- Overflow / underflow:
  - in_exp = 254, prod[47] = 1, sign 1 → 32'hFF800000 with overflow = 1.
  - in_exp = 10'h3F0 (−16), sign 0 → 32'h00000000 with underflow = 1.
- Specials: code 11 → 32'h7FC00000. Code 10 with sign 1 → 32'hFF800000. Code 01 with sign 1 → 32'h80000000. All with flags 0 regardless of prod and exp.
- Backpressure:
  - Setup: out_ready = 0 while 4 back-to-back valid inputs are offered.
  - While out_ready = 0: 2 inputs are accepted, then in_ready = 0, and out_result is held stable.
  - After out_ready returns to 1: all 4 results emerge in order with no gaps beyond pipeline refill.
- Reset mid-flight: assert n_rst = 0 with both stages full → out_valid = 0, out_result = 0, flags 0, in_ready = 1 immediately (asynchronous). No stale result appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants and special-operand codes for the
// multiplier and adder back ends.
package fp_pkg;

    localparam int          FP_BIAS  = 127;
    localparam int          FP_EXP_W = 10;
    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;

    typedef enum logic [1:0] {
        FP_NORM = 2'b00,
        FP_ZERO = 2'b01,
        FP_INF  = 2'b10,
        FP_NAN  = 2'b11
    } fp_special_e;

endpackage

// File: rtl/fp_mul_round_pack_if.sv
// Valid/ready bundle between the multiplier core, the round/pack stage and
// the downstream consumer.
interface fp_mul_round_pack_if;

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sign;
    logic [fp_pkg::FP_EXP_W-1:0] in_exp;
    logic [47:0]                 in_prod;
    logic [1:0]                  in_special;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_result;
    logic                        out_overflow;
    logic                        out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_special, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_special, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational normalize of a 48-bit significand product plus
// round-to-nearest-even to a 23-bit fraction.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [47:0]         prod_i,
    input  logic [FP_EXP_W-1:0] exp_i,
    output logic [22:0]         mant_o,
    output logic [FP_EXP_W-1:0] exp_o
);

    logic [22:0]         normMant;
    logic                guardBit;
    logic                stickyBit;
    logic [FP_EXP_W-1:0] normExp;
    logic                roundUp;
    logic [23:0]         roundSum;

    always_comb begin
        normMant  = prod_i[45:23];
        guardBit  = prod_i[22];
        stickyBit = |prod_i[21:0];
        normExp   = exp_i;
        if (prod_i[47]) begin
            normMant  = prod_i[46:24];
            guardBit  = prod_i[23];
            stickyBit = |prod_i[22:0];
            normExp   = exp_i + 10'd1;
        end
    end

    // A carry out of the 23-bit fraction leaves it all-zero, so only the exponent moves.
    assign roundUp  = guardBit & (stickyBit | normMant[0]);
    assign roundSum = {1'b0, normMant} + {23'd0, roundUp};
    assign mant_o   = roundSum[22:0];
    assign exp_o    = normExp + {9'd0, roundSum[23]};

endmodule

// File: rtl/fp_mul_round_pack.sv
// Two-stage valid/ready back end of the multiplier: normalize/round into s1,
// then pack with overflow/underflow and special-operand override.
module fp_mul_round_pack
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    fp_mul_round_pack_if.slave  bus
);

    logic                s1Valid_q;
    logic                s1Sign_q;
    fp_special_e         s1Special_q;
    logic [22:0]         s1Mant_q;
    logic [FP_EXP_W-1:0] s1Exp_q;

    logic                outValid_q;
    logic [31:0]         outResult_q, outResult_d;
    logic                outOverflow_q, outOverflow_d;
    logic                outUnderflow_q, outUnderflow_d;

    logic                s1Advance;
    logic                inAccept;
    logic [22:0]         rndMant;
    logic [FP_EXP_W-1:0] rndExp;

    fp_round_rne u_round (
        .prod_i (bus.in_prod),
        .exp_i  (bus.in_exp),
        .mant_o (rndMant),
        .exp_o  (rndExp)
    );

    assign s1Advance    = !outValid_q || bus.out_ready;
    assign bus.in_ready = !s1Valid_q || s1Advance;
    assign inAccept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1Valid_q   <= 1'b0;
            s1Sign_q    <= 1'b0;
            s1Special_q <= FP_NORM;
            s1Mant_q    <= '0;
            s1Exp_q     <= '0;
        end else begin
            if (bus.in_ready) s1Valid_q <= bus.in_valid;
            if (inAccept) begin
                s1Sign_q    <= bus.in_sign;
                s1Special_q <= fp_special_e'(bus.in_special);
                s1Mant_q    <= rndMant;
                s1Exp_q     <= rndExp;
            end
        end
    end

    // Exponent compares are signed so that negative sums land in underflow.
    always_comb begin
        outResult_d    = {s1Sign_q, s1Exp_q[7:0], s1Mant_q};
        outOverflow_d  = 1'b0;
        outUnderflow_d = 1'b0;
        case (s1Special_q)
            FP_ZERO: outResult_d = {s1Sign_q, 31'h0};
            FP_INF:  outResult_d = {s1Sign_q, 8'hFF, 23'h0};
            FP_NAN:  outResult_d = FP_QNAN;
            default: begin
                if ($signed(s1Exp_q) >= 10'sd255) begin
                    outResult_d   = {s1Sign_q, 8'hFF, 23'h0};
                    outOverflow_d = 1'b1;
                end else if ($signed(s1Exp_q) <= 10'sd0) begin
                    outResult_d    = {s1Sign_q, 31'h0};
                    outUnderflow_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            outValid_q     <= 1'b0;
            outResult_q    <= 32'h0;
            outOverflow_q  <= 1'b0;
            outUnderflow_q <= 1'b0;
        end else if (s1Advance) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outResult_q    <= outResult_d;
                outOverflow_q  <= outOverflow_d;
                outUnderflow_q <= outUnderflow_d;
            end
        end
    end

    assign bus.out_valid     = outValid_q;
    assign bus.out_result    = outResult_q;
    assign bus.out_overflow  = outOverflow_q;
    assign bus.out_underflow = outUnderflow_q;

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed self-checking bench for the multiplier round/pack stage: rounding,
// range limits, specials, backpressure and asynchronous reset.
module tb_fp_mul_round_pack;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    int   checkCount = 0;
    int   passCount  = 0;

    fp_mul_round_pack_if bus ();

    fp_mul_round_pack dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic sign, input logic [9:0] exp, input logic [47:0] prod, input logic [1:0] special);
        bus.in_valid   = 1'b1;
        bus.in_sign    = sign;
        bus.in_exp     = exp;
        bus.in_prod    = prod;
        bus.in_special = special;
    endtask

    // One isolated transaction with out_ready high; result is checked two edges later.
    task automatic runVector(input string tag, input logic sign, input logic [9:0] exp, input logic [47:0] prod,
                             input logic [1:0] special, input logic [31:0] expResult, input logic expOv, input logic expUf);
        @(negedge clk);
        applyStimulus(sign, exp, prod, special);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        checkOutput({tag, ".result"}, bus.out_result, expResult);
        checkOutput({tag, ".ovf"}, {31'd0, bus.out_overflow}, {31'd0, expOv});
        checkOutput({tag, ".udf"}, {31'd0, bus.out_underflow}, {31'd0, expUf});
    endtask

    initial begin
        n_rst          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_exp     = '0;
        bus.in_prod    = '0;
        bus.in_special = 2'b00;
        bus.out_ready  = 1'b1;
        $display("[TB] start");

        #12;
        checkOutput("rst.inReady", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst.outValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst.result", bus.out_result, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        runVector("mul1p5",   1'b0, 10'(FP_BIAS), 48'h900000000000, 2'b00, 32'h40100000, 1'b0, 1'b0);
        runVector("roundUp",  1'b0, 10'(FP_BIAS), 48'h400000C00000, 2'b00, 32'h3F800002, 1'b0, 1'b0);
        runVector("tieEven",  1'b0, 10'(FP_BIAS), 48'h400000400000, 2'b00, 32'h3F800000, 1'b0, 1'b0);
        runVector("carry",    1'b0, 10'(FP_BIAS), 48'h7FFFFFC00000, 2'b00, 32'h40000000, 1'b0, 1'b0);
        runVector("overflow", 1'b1, 10'd254,      48'h800000000000, 2'b00, 32'hFF800000, 1'b1, 1'b0);
        runVector("maxNorm",  1'b0, 10'd253,      48'h800000000000, 2'b00, 32'h7F000000, 1'b0, 1'b0);
        runVector("underflow",1'b0, 10'h3F0,      48'h400000000000, 2'b00, 32'h00000000, 1'b0, 1'b1);
        runVector("minNorm",  1'b0, 10'd0,        48'h800000000000, 2'b00, 32'h00800000, 1'b0, 1'b0);
        runVector("expZero",  1'b1, 10'd0,        48'h400000000000, 2'b00, 32'h80000000, 1'b0, 1'b1);
        runVector("nan",      1'b1, 10'd300,      48'hFFFFFFFFFFFF, 2'b11, 32'h7FC00000, 1'b0, 1'b0);
        runVector("inf",      1'b1, 10'h3F0,      48'h123456789ABC, 2'b10, 32'hFF800000, 1'b0, 1'b0);
        runVector("zero",     1'b1, 10'd254,      48'h900000000000, 2'b01, 32'h80000000, 1'b0, 1'b0);

        // Backpressure: four back-to-back items, downstream stalled at first.
        @(negedge clk);
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 10'd126, 48'h800000000000, 2'b00);
        #1 checkOutput("bp.acc0", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 10'd127, 48'h800000000000, 2'b00);
        #1 checkOutput("bp.acc1", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 10'd128, 48'h800000000000, 2'b00);
        #1 checkOutput("bp.full", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp.out0", bus.out_result, 32'h3F800000);
        @(negedge clk);
        checkOutput("bp.stillFull", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp.hold0", bus.out_result, 32'h3F800000);
        checkOutput("bp.holdValid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        #1 checkOutput("bp.release", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        checkOutput("bp.out1", bus.out_result, 32'h40000000);
        applyStimulus(1'b0, 10'd129, 48'h800000000000, 2'b00);
        @(negedge clk);
        checkOutput("bp.out2", bus.out_result, 32'h40800000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp.out3", bus.out_result, 32'h41000000);
        checkOutput("bp.valid3", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        checkOutput("bp.drained", {31'd0, bus.out_valid}, 32'd0);

        // Reset with both stages holding data.
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 10'd254, 48'h800000000000, 2'b00);
        @(negedge clk);
        applyStimulus(1'b0, 10'd127, 48'h800000000000, 2'b00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("mid.ovfBefore", {31'd0, bus.out_overflow}, 32'd1);
        checkOutput("mid.fullBefore", {31'd0, bus.in_ready}, 32'd0);
        n_rst = 1'b0;
        #1;
        checkOutput("mid.outValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("mid.result", bus.out_result, 32'h0);
        checkOutput("mid.flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
        checkOutput("mid.inReady", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post.noStale%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
